crack_scheduler: RTL
====================

# crack_scheduler

Key-space scheduler for the ARC4 key-search engine. It splits the 24-bit key space into fixed-size chunks and dispatches them to NW independent crack workers, refilling each worker as it finishes. It stops all workers once a key is found and reports a single result. It sits above the crack worker instances, in place of a static even/odd key interleave, so worker count and load balancing scale without changing the workers.

## Interface
- NW, 2, number of crack workers (1..8)
- CHUNK_LOG2, 16, log2 of keys per chunk (1..24)
- KEY_MAX, 24'hFFFFFF, last key in the search space (inclusive)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  start request; honoured only while rdy=1
- rdy  out  1  idle / result available
- key  out  24  found key; valid when key_valid=1
- key_valid  out  1  last search found a key
- abort  out  1  one-cycle pulse telling all busy workers to stop
- wk_start  out  NW  one-hot one-cycle pulse: launch worker i on a chunk
- wk_base  out  24  first key of the dispatched chunk; valid with wk_start
- wk_last  out  24  last key (inclusive) of the dispatched chunk; valid with wk_start
- wk_done  in  NW  one-cycle pulse: worker i finished (chunk exhausted, key found, or aborted)
- wk_found  in  NW  qualifies wk_done[i]: worker i found a key
- wk_key  in  NW*24  worker i key in bits [24i+23:24i]; valid with wk_done[i] & wk_found[i]

## Operation
- State machine: IDLE, RUN, DRAIN.
- Internal state: next_base (25 bits), exhausted flag, outstanding[NW] bitmap, round-robin pointer rr, found_key register.
- IDLE:
  - rdy=1.
  - en=1: clear next_base, exhausted, outstanding and key_valid; set rr=0; go to RUN.
- RUN, evaluated each cycle in this priority order:
  1. Any wk_done[i] & wk_found[i] & outstanding[i]: capture wk_key of the lowest such i; pulse abort; go to DRAIN. No dispatch this cycle.
  2. Otherwise, if !exhausted and an idle worker exists: dispatch one chunk to the first idle worker at or after rr (wrapping).
     - wk_base = next_base.
     - wk_last = min(next_base + 2^CHUNK_LOG2 − 1, KEY_MAX).
     - Set outstanding[i]; rr = i+1 mod NW; next_base += 2^CHUNK_LOG2.
     - Set exhausted when wk_last == KEY_MAX.
  3. If exhausted and outstanding==0: key_valid=0; go to IDLE.
- Idle worker: outstanding[i]=0, sampled at the start of the cycle. A worker whose wk_done arrives in cycle c becomes eligible in cycle c+1.
- wk_done clears outstanding[i] in every state.
- wk_done for a non-outstanding worker is ignored, including its found flag.
- DRAIN:
  - Waits until outstanding==0, counting aborted workers' wk_done; further founds are ignored.
  - Then key=found_key, key_valid=1, go to IDLE.
- At most one wk_start bit per cycle.
- en while rdy=0 is ignored.
- key and key_valid hold their values until the next accepted en (key_valid clears) or reset.
- Arithmetic: next_base is 25 bits so it cannot wrap past KEY_MAX. wk_last is clamped, so the final chunk may be short.

## Timing
- Reset values: rdy=1, key=0, key_valid=0, abort=0, wk_start=0, wk_base=0, wk_last=0; state IDLE; internal registers cleared.
- Reset mid-search returns to IDLE next cycle with no abort pulse. Workers share rst_n.
- All outputs are registered.
- en accepted at edge t: rdy=0 from t+1, and the first wk_start is also high from t+1.
- With all workers idle, workers get starts in consecutive cycles t+1..t+NW.
- Found wk_done in cycle c: abort high during cycle c+1 only.
- rdy and key_valid rise together one cycle after the cycle in which outstanding becomes 0.
- Simultaneous founds: the lowest index wins.
- Found simultaneous with another worker's non-found done: found wins; the other worker's bit is still cleared.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → rdy=1, key_valid=0, key=0, wk_start=0, abort=0.
- Dispatch (NW=2, CHUNK_LOG2=22): pulse en → wk_start=01 with base 000000 / last 3FFFFF, next cycle wk_start=10 with base 400000 / last 7FFFFF. wk_done[0] (not found) → worker 0 next gets 800000 / BFFFFF.
- Find: worker 1 pulses done+found with key 0x400123 → abort pulse 1 cycle later. Worker 0 then pulses done → rdy=1, key_valid=1, key=0x400123 the following cycle.
- Exhaustion (NW=2, CHUNK_LOG2=22): no finds → exactly 4 chunks issued, last C00000 / FFFFFF. After final done → rdy=1, key_valid=0.
- Truncation (KEY_MAX=24'h00000A, CHUNK_LOG2=2, NW=2) → chunks 0–3, 4–7, 8–A, and no chunk after 8–A.
- Simultaneous found from workers 0 (0x000005) and 1 (0x400007) in the same cycle → key=0x000005. Then assert rst_n=0 mid-RUN on a new search → IDLE, rdy=1, key_valid=0, no abort pulse.

Source files
------------

// File: rtl/crack_scheduler_if.sv
// Worker-side bus between the key-space scheduler and its crack workers.
// The scheduler drives chunk launches and abort; workers report completion.
interface crack_scheduler_if #(
    parameter int NW = 2
);
    logic [NW-1:0]    wk_start;
    logic [23:0]      wk_base;
    logic [23:0]      wk_last;
    logic             abort;
    logic [NW-1:0]    wk_done;
    logic [NW-1:0]    wk_found;
    logic [NW*24-1:0] wk_key;

    modport master (
        output wk_start, wk_base, wk_last, abort,
        input  wk_done, wk_found, wk_key
    );

    modport slave (
        input  wk_start, wk_base, wk_last, abort,
        output wk_done, wk_found, wk_key
    );
endinterface

// File: rtl/crack_scheduler.sv
// Splits the 24-bit ARC4 key space into chunks, hands them round-robin to NW
// workers, aborts everyone on the first found key and reports one result.
module crack_scheduler #(
    parameter int          NW         = 2,
    parameter int          CHUNK_LOG2 = 16,
    parameter logic [23:0] KEY_MAX    = 24'hFFFFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    output logic                 rdy,
    output logic [23:0]          key,
    output logic                 key_valid,
    crack_scheduler_if.master    wk
);
    localparam int          RRW       = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [24:0] CHUNK     = 25'd1 << CHUNK_LOG2;
    localparam logic [24:0] KEY_MAX_W = {1'b0, KEY_MAX};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          state_q;
    logic [24:0]     next_base_q;
    logic            exhausted_q;
    logic [NW-1:0]   outstanding_q;
    logic [RRW-1:0]  rr_q;
    logic [23:0]     found_key_q;
    logic [23:0]     key_q;
    logic            key_valid_q;
    logic            rdy_q;
    logic            abort_q;
    logic [NW-1:0]   wk_start_q;
    logic [23:0]     wk_base_q;
    logic [23:0]     wk_last_q;

    logic [23:0]     key_arr [NW];
    logic [NW-1:0]   found_vec;
    logic [NW-1:0]   out_after;
    logic [23:0]     found_key_d;

    // Done pulses only count for workers we actually launched.
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_worker
            assign key_arr[gi]   = wk.wk_key[24*gi +: 24];
            assign found_vec[gi] = wk.wk_done[gi] & wk.wk_found[gi] & outstanding_q[gi];
        end
    endgenerate

    assign out_after = outstanding_q & ~wk.wk_done;

    always_comb begin
        found_key_d = '0;
        for (int i = NW - 1; i >= 0; i--) begin
            if (found_vec[i]) found_key_d = key_arr[i];
        end
    end

    // In IDLE the dispatch is computed from a freshly cleared context so the
    // first chunk can launch on the same edge that accepts en.
    logic [24:0]     cur_base;
    logic [NW-1:0]   cur_out;
    logic [RRW-1:0]  cur_rr;
    logic            disp_ok;
    logic [RRW-1:0]  disp_idx;
    logic [NW-1:0]   disp_onehot;
    logic [24:0]     chunk_end;
    logic [23:0]     disp_last;
    logic [RRW-1:0]  rr_d;

    always_comb begin
        cur_base = (state_q == S_IDLE) ? 25'd0 : next_base_q;
        cur_out  = (state_q == S_IDLE) ? '0 : outstanding_q;
        cur_rr   = (state_q == S_IDLE) ? '0 : rr_q;
        disp_ok  = 1'b0;
        disp_idx = '0;
        for (int k = 0; k < NW; k++) begin
            int idx;
            idx = int'(cur_rr) + k;
            if (idx >= NW) idx = idx - NW;
            if (!disp_ok && !cur_out[idx]) begin
                disp_ok  = 1'b1;
                disp_idx = RRW'(idx);
            end
        end
        disp_onehot = NW'(1) << disp_idx;
        chunk_end   = cur_base + CHUNK - 25'd1;
        disp_last   = (chunk_end > KEY_MAX_W) ? KEY_MAX : chunk_end[23:0];
        rr_d        = (disp_idx == RRW'(NW - 1)) ? '0 : disp_idx + RRW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            next_base_q   <= '0;
            exhausted_q   <= 1'b0;
            outstanding_q <= '0;
            rr_q          <= '0;
            found_key_q   <= '0;
            key_q         <= '0;
            key_valid_q   <= 1'b0;
            rdy_q         <= 1'b1;
            abort_q       <= 1'b0;
            wk_start_q    <= '0;
            wk_base_q     <= '0;
            wk_last_q     <= '0;
        end else begin
            wk_start_q    <= '0;
            abort_q       <= 1'b0;
            outstanding_q <= out_after;
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        key_valid_q   <= 1'b0;
                        rdy_q         <= 1'b0;
                        state_q       <= S_RUN;
                        wk_start_q    <= disp_onehot;
                        wk_base_q     <= cur_base[23:0];
                        wk_last_q     <= disp_last;
                        outstanding_q <= disp_onehot;
                        rr_q          <= rr_d;
                        next_base_q   <= cur_base + CHUNK;
                        exhausted_q   <= (disp_last == KEY_MAX);
                    end
                end
                S_RUN: begin
                    if (|found_vec) begin
                        found_key_q <= found_key_d;
                        abort_q     <= 1'b1;
                        state_q     <= S_DRAIN;
                    end else if (!exhausted_q && disp_ok) begin
                        wk_start_q    <= disp_onehot;
                        wk_base_q     <= cur_base[23:0];
                        wk_last_q     <= disp_last;
                        outstanding_q <= out_after | disp_onehot;
                        rr_q          <= rr_d;
                        next_base_q   <= cur_base + CHUNK;
                        exhausted_q   <= (disp_last == KEY_MAX);
                    end else if (exhausted_q && out_after == '0) begin
                        key_valid_q <= 1'b0;
                        rdy_q       <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (out_after == '0) begin
                        key_q       <= found_key_q;
                        key_valid_q <= 1'b1;
                        rdy_q       <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rdy         = rdy_q;
    assign key         = key_q;
    assign key_valid   = key_valid_q;
    assign wk.abort    = abort_q;
    assign wk.wk_start = wk_start_q;
    assign wk.wk_base  = wk_base_q;
    assign wk.wk_last  = wk_last_q;
endmodule
